// File: rtl/ip_pkg.sv
// Shared constants and FSM state type for the Ethernet-to-IP frame assembler.
// The optional drop counter is enabled with the IP_ASM_DROP_CNT_EN macro (see top).
package ip_pkg;

  localparam int          ETH_HDR_LEN    = 14;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam int          IPH_LEN        = 20;
  localparam int          TCPH_LEN       = 20;
  localparam int          PAYLOAD_LEN    = 262;

  // Largest datagram the assembler can hold, and the width of the output vector.
  localparam int MAXLEN = PAYLOAD_LEN + TCPH_LEN + IPH_LEN;
  localparam int DATA_W = MAXLEN * 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ETH_HDR = 3'd1,
    IP_BODY = 3'd2,
    PAD     = 3'd3,
    DRAIN   = 3'd4,
    EMIT    = 3'd5
  } asm_state_e;

endpackage

// File: rtl/ip_frame_assembler_if.sv
// Byte stream from the MAC into the assembler, plus the assembled-datagram output.
// A byte moves on a rising edge where rx_valid && rx_ready; rx_last only has meaning
// on such a transfer, and ip_frame_valid is a single-cycle strobe with no back-pressure.
interface ip_frame_assembler_if #(
  parameter int DATA_W = ip_pkg::DATA_W
);

  logic [7:0]        rx_byte;
  logic              rx_valid;
  logic              rx_last;
  logic              rx_ready;
  logic [DATA_W-1:0] rx_ip_data;
  logic [15:0]       ip_len;
  logic              ip_frame_valid;

  modport slave (
    input  rx_byte, rx_valid, rx_last,
    output rx_ready, rx_ip_data, ip_len, ip_frame_valid
  );

  modport master (
    output rx_byte, rx_valid, rx_last,
    input  rx_ready, rx_ip_data, ip_len, ip_frame_valid
  );

endinterface

// File: rtl/ip_byte_buffer.sv
// Left-aligned byte buffer: byte index 0 lands in the top 8 bits of rd_data.
// Synchronous clear takes priority over a write in the same cycle.
module ip_byte_buffer #(
  parameter int DEPTH = ip_pkg::MAXLEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               wr_en,
  input  logic [15:0]        wr_idx,
  input  logic [7:0]         wr_byte,
  output logic [DEPTH*8-1:0] rd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem_d[i] = 8'h00;
    end else if (wr_en && (wr_idx < 16'(DEPTH))) begin
      mem_d[wr_idx[AW-1:0]] = wr_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_rd
    assign rd_data[DEPTH*8-1-8*g -: 8] = mem_q[g];
  end

endmodule

// File: rtl/ip_frame_assembler.sv
// Strips the Ethernet header, validates EtherType and IPv4 Total Length, and emits the
// datagram as one left-aligned vector. Define IP_ASM_DROP_CNT_EN to add the drop_cnt port.
module ip_frame_assembler #(
  parameter int          PAYLOAD_LEN = ip_pkg::PAYLOAD_LEN,
  parameter int          TCPH_LEN    = ip_pkg::TCPH_LEN,
  parameter int          IPH_LEN     = ip_pkg::IPH_LEN,
  parameter int          ETH_HDR_LEN = ip_pkg::ETH_HDR_LEN,
  parameter logic [15:0] ETHERTYPE   = ip_pkg::ETHERTYPE_IPV4
) (
  input  logic                  clk,
  input  logic                  rst,
  ip_frame_assembler_if.slave   rx,
  output ip_pkg::asm_state_e    dbg_state
`ifdef IP_ASM_DROP_CNT_EN
  ,
  output logic [15:0]           drop_cnt
`endif
);

  import ip_pkg::*;

  localparam int MAX_LEN = PAYLOAD_LEN + TCPH_LEN + IPH_LEN;
  localparam int DW      = MAX_LEN * 8;

  asm_state_e      state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [15:0]     tot_len_q, tot_len_d;
  logic [7:0]      etype_hi_q, etype_hi_d;
  logic [DW-1:0]   ip_data_q, ip_data_d;
  logic [15:0]     ip_len_q, ip_len_d;

  logic            fire;
  logic            drop_evt;
  logic            buf_wr;
  logic            buf_clr;
  logic [DW-1:0]   buf_data;
  logic [15:0]     cnt_inc;
  logic [15:0]     len_now;

  assign fire    = rx.rx_valid && (state_q != EMIT);
  assign cnt_inc = cnt_q + 16'd1;
  // On IP byte 3 the low half of Total Length is still on the bus, not yet in tot_len_q.
  assign len_now = (cnt_q == 16'd3) ? {tot_len_q[15:8], rx.rx_byte} : tot_len_q;
  // Emit and every drop leave the buffer zeroed, so bytes beyond Total Length read as 0.
  assign buf_clr = (state_q == EMIT) || drop_evt;

  ip_byte_buffer #(
    .DEPTH (MAX_LEN)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .clr     (buf_clr),
    .wr_en   (buf_wr),
    .wr_idx  (cnt_q),
    .wr_byte (rx.rx_byte),
    .rd_data (buf_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tot_len_d  = tot_len_q;
    etype_hi_d = etype_hi_q;
    drop_evt   = 1'b0;
    buf_wr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (fire) begin
          if (rx.rx_last) begin
            drop_evt = 1'b1;
          end else begin
            cnt_d   = 16'd1;
            state_d = ETH_HDR;
          end
        end
      end
      ETH_HDR: begin
        if (fire) begin
          cnt_d = cnt_inc;
          if (cnt_q == 16'(ETH_HDR_LEN - 2)) etype_hi_d = rx.rx_byte;
          if (cnt_q == 16'(ETH_HDR_LEN - 1)) begin
            if ({etype_hi_q, rx.rx_byte} != ETHERTYPE) begin
              drop_evt = 1'b1;
              state_d  = rx.rx_last ? IDLE : DRAIN;
            end else if (rx.rx_last) begin
              drop_evt = 1'b1;
              state_d  = IDLE;
            end else begin
              cnt_d   = 16'd0;
              state_d = IP_BODY;
            end
          end else if (rx.rx_last) begin
            drop_evt = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      IP_BODY: begin
        if (fire) begin
          buf_wr = 1'b1;
          cnt_d  = cnt_inc;
          if (cnt_q == 16'd2) tot_len_d[15:8] = rx.rx_byte;
          if (cnt_q == 16'd3) tot_len_d[7:0]  = rx.rx_byte;
          if ((cnt_q == 16'd3) &&
              ((len_now < 16'(IPH_LEN)) || (len_now > 16'(MAX_LEN)))) begin
            drop_evt = 1'b1;
            state_d  = rx.rx_last ? IDLE : DRAIN;
          end else if ((cnt_q >= 16'd3) && (cnt_inc == len_now)) begin
            state_d = rx.rx_last ? EMIT : PAD;
          end else if (rx.rx_last) begin
            drop_evt = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      PAD: begin
        if (fire && rx.rx_last) state_d = EMIT;
      end
      DRAIN: begin
        if (fire && rx.rx_last) state_d = IDLE;
      end
      EMIT: begin
        cnt_d   = 16'd0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // During EMIT the outputs show the live buffer; afterwards they show the captured copy.
  always_comb begin
    rx.rx_ready       = (state_q != EMIT);
    rx.ip_frame_valid = (state_q == EMIT);
    rx.rx_ip_data     = (state_q == EMIT) ? buf_data : ip_data_q;
    rx.ip_len         = (state_q == EMIT) ? tot_len_q : ip_len_q;
    dbg_state         = state_q;
  end

  always_comb begin
    ip_data_d = ip_data_q;
    ip_len_d  = ip_len_q;
    if (state_q == EMIT) begin
      ip_data_d = buf_data;
      ip_len_d  = tot_len_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= 16'd0;
      tot_len_q  <= 16'd0;
      etype_hi_q <= 8'h00;
      ip_data_q  <= '0;
      ip_len_q   <= 16'd0;
    end else begin
      cnt_q      <= cnt_d;
      tot_len_q  <= tot_len_d;
      etype_hi_q <= etype_hi_d;
      ip_data_q  <= ip_data_d;
      ip_len_q   <= ip_len_d;
    end
  end

`ifdef IP_ASM_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_evt && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= 16'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule
